// File: rtl/batalha_pkg.sv
// Shared definitions for the game memory subsystem.
// Holds the client index map (lower index = higher priority), default memory
// geometry, and a helper that sizes the per-client player-select field.
package batalha_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_ADDR_W = 5;

  localparam int unsigned CLI_VALIDADOR = 0;
  localparam int unsigned CLI_COLISOR   = 1;
  localparam int unsigned CLI_PONTUACAO = 2;
  localparam int unsigned CLI_VGA       = 3;
  localparam int unsigned NUM_CLI       = 4;

  // Player-select width; at least one bit even for a single bank.
  function automatic int unsigned psel_width(input int unsigned n_players);
    return (n_players > 1) ? $clog2(n_players) : 1;
  endfunction

endpackage

// File: rtl/prio_encoder_mask.sv
// Fixed-priority encoder with an exclusion mask.
// Ports:
//   req_i   - request vector, bit 0 is highest priority
//   mask_i  - requests to ignore for this decision
//   gnt_o   - one-hot pick of the lowest-index unmasked request
//   valid_o - at least one unmasked request present
module prio_encoder_mask #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  logic [N-1:0] cand;

  assign cand    = req_i & ~mask_i;
  // Isolate the lowest set bit.
  assign gnt_o   = cand & (~cand + N'(1));
  assign valid_o = |cand;

endmodule

// File: rtl/arbitro_memoria.sv
// Memory arbiter: N_CLIENTS requesters share one port onto N_PLAYERS banks.
// Lowest index wins; a client holding lock keeps the grant until it drops
// req/lock or has held for MAX_HOLD cycles while someone else waits.
// Ports:
//   clk, resetGeral      - clock, synchronous active-high reset
//   req/lock/we          - per-client request, grant hold, write flag
//   sel/addr/wdata       - per-client bank select, address, write data
//   mem_rdata            - per-bank read data (valid the cycle after address)
//   gnt                  - one-hot current owner
//   rvalid/rdata         - read response, one cycle after the access
//   mem_addr/mem_wdata   - address/write data muxed from the owner
//   mem_wren             - per-bank write enable
//   sel_err              - pulse one cycle after an access to a missing bank
module arbitro_memoria
  import batalha_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned N_CLIENTS = NUM_CLI,
  parameter int unsigned MAX_HOLD  = 16,
  localparam int unsigned PSEL_W   = psel_width(N_PLAYERS),
  localparam int unsigned IDX_W    = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic                        clk,
  input  logic                        resetGeral,
  input  logic [N_CLIENTS-1:0]        req,
  input  logic [N_CLIENTS-1:0]        lock,
  input  logic [N_CLIENTS-1:0]        we,
  input  logic [N_CLIENTS*PSEL_W-1:0] sel,
  input  logic [N_CLIENTS*ADDR_W-1:0] addr,
  input  logic [N_CLIENTS*DATA_W-1:0] wdata,
  input  logic [N_PLAYERS*DATA_W-1:0] mem_rdata,
  output logic [N_CLIENTS-1:0]        gnt,
  output logic [N_CLIENTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [N_PLAYERS-1:0]        mem_wren,
  output logic                        sel_err
);

  logic [IDX_W-1:0]     own_q, own_d;
  logic                 own_v_q, own_v_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 rd_v_q, rd_v_d;
  logic [IDX_W-1:0]     rd_cli_q;
  logic [PSEL_W-1:0]    rd_bank_q;
  logic                 sel_err_q, sel_err_d;

  logic [N_CLIENTS-1:0] own_oh, mask, pick_oh;
  logic                 pick_v, timeout, keep, acc, sel_ok;
  logic [IDX_W-1:0]     pick_idx;
  logic [PSEL_W-1:0]    sel_own;

  always_comb begin
    own_oh = '0;
    own_oh[own_q] = own_v_q;
  end

  assign timeout = own_v_q && (hold_cnt_q == HOLD_W'(MAX_HOLD)) && |(req & ~own_oh);
  assign keep    = own_v_q && req[own_q] && lock[own_q] && !timeout;
  // On timeout the current owner sits out exactly one decision.
  assign mask    = timeout ? own_oh : '0;

  prio_encoder_mask #(
    .N (N_CLIENTS)
  ) u_prio (
    .req_i   (req),
    .mask_i  (mask),
    .gnt_o   (pick_oh),
    .valid_o (pick_v)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (pick_oh[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    own_d   = own_q;
    own_v_d = own_v_q;
    if (!keep) begin
      own_v_d = pick_v;
      own_d   = pick_v ? pick_idx : '0;
    end
    if ((own_d != own_q) || (own_v_d != own_v_q)) begin
      hold_cnt_d = '0;
    end else if (own_v_q && (hold_cnt_q != HOLD_W'(MAX_HOLD))) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Access datapath, muxed from the owner.
  assign acc     = own_v_q && req[own_q];
  assign sel_own = sel[own_q*PSEL_W +: PSEL_W];
  assign sel_ok  = 32'(sel_own) < N_PLAYERS;

  assign gnt       = own_oh;
  assign mem_addr  = own_v_q ? addr[own_q*ADDR_W +: ADDR_W]  : '0;
  assign mem_wdata = own_v_q ? wdata[own_q*DATA_W +: DATA_W] : '0;

  always_comb begin
    mem_wren = '0;
    for (int unsigned b = 0; b < N_PLAYERS; b++) begin
      mem_wren[b] = acc && we[own_q] && (sel_own == PSEL_W'(b));
    end
  end

  assign rd_v_d    = acc && !we[own_q] && sel_ok;
  assign sel_err_d = acc && !sel_ok;

  always_ff @(posedge clk) begin
    if (resetGeral) begin
      own_q      <= '0;
      own_v_q    <= 1'b0;
      hold_cnt_q <= '0;
      rd_v_q     <= 1'b0;
      rd_cli_q   <= '0;
      rd_bank_q  <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      own_q      <= own_d;
      own_v_q    <= own_v_d;
      hold_cnt_q <= hold_cnt_d;
      rd_v_q     <= rd_v_d;
      rd_cli_q   <= own_q;
      rd_bank_q  <= sel_own;
      sel_err_q  <= sel_err_d;
    end
  end

  always_comb begin
    rvalid = '0;
    rvalid[rd_cli_q] = rd_v_q;
  end

  assign rdata   = rd_v_q ? mem_rdata[rd_bank_q*DATA_W +: DATA_W] : '0;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
module tb_arbitro_memoria;

  localparam int NC = 4;
  localparam int NP = 3;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int PW = 2;
  localparam int MH = 16;

  logic                clk = 1'b0;
  logic                resetGeral;
  logic [NC-1:0]       req, lock, we;
  logic [NC*PW-1:0]    sel;
  logic [NC*AW-1:0]    addr;
  logic [NC*DW-1:0]    wdata;
  logic [NP*DW-1:0]    mem_rdata;
  logic [NC-1:0]       gnt, rvalid;
  logic [DW-1:0]       rdata, mem_wdata;
  logic [AW-1:0]       mem_addr;
  logic [NP-1:0]       mem_wren;
  logic                sel_err;

  always #5 clk = ~clk;

  arbitro_memoria #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .N_PLAYERS (NP),
    .N_CLIENTS (NC),
    .MAX_HOLD  (MH)
  ) dut (
    .clk        (clk),
    .resetGeral (resetGeral),
    .req        (req),
    .lock       (lock),
    .we         (we),
    .sel        (sel),
    .addr       (addr),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .sel_err    (sel_err)
  );

  // Bench-side banks: synchronous read, driven by the DUT's memory port.
  logic [DW-1:0] bmem [NP][32];
  logic [DW-1:0] rd_q [NP];
  assign mem_rdata = {rd_q[2], rd_q[1], rd_q[0]};
  always @(posedge clk) begin
    for (int b = 0; b < NP; b++) begin
      rd_q[b] <= bmem[b][mem_addr];
      if (mem_wren[b]) bmem[b][mem_addr] <= mem_wdata;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [NP][32];
  int   m_own, m_hold;
  bit   m_v;
  bit   known = 0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct {
    int            due;
    logic [NC-1:0] rv;
    logic          err;
    logic [DW-1:0] data;
  } resp_t;
  resp_t sbq[$];

  // Per-client stimulus fields, applied by step().
  logic [NC-1:0]    s_we;
  logic [NC*PW-1:0] s_sel;
  logic [NC*AW-1:0] s_addr;
  logic [NC*DW-1:0] s_wdata;

  task automatic cli(input int i, input logic w, input int s, input int a, input logic [DW-1:0] d);
    s_we[i]            = w;
    s_sel[i*PW +: PW]  = PW'(s);
    s_addr[i*AW +: AW] = AW'(a);
    s_wdata[i*DW +: DW] = d;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [NC-1:0] rq, input logic [NC-1:0] lk);
    logic [NC-1:0] eg;
    logic [NP-1:0] ewren;
    logic [DW-1:0] ewd;
    int b, a, no, nh;
    bit nv, others, tmo;
    resp_t e;
    resetGeral = r; req = rq; lock = lk;
    we = s_we; sel = s_sel; addr = s_addr; wdata = s_wdata;
    eg = '0; ewren = '0; ewd = '0;
    if (m_v) eg[m_own] = 1'b1;
    if (known && m_v && rq[m_own]) begin
      b = int'(s_sel[m_own*PW +: PW]);
      a = int'(s_addr[m_own*AW +: AW]);
      if (b >= NP) begin
        if (!r) begin
          e.due = cyc + 1; e.rv = '0; e.err = 1'b1; e.data = '0;
          sbq.push_back(e);
        end
      end else if (s_we[m_own]) begin
        ewren[b] = 1'b1;
        ewd = s_wdata[m_own*DW +: DW];
        ref_mem[b][a] = ewd;
      end else if (!r) begin
        e.due = cyc + 1; e.rv = '0; e.rv[m_own] = 1'b1; e.err = 1'b0; e.data = ref_mem[b][a];
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    if (known) begin
      chk("gnt", DW'(gnt), DW'(eg));
      chk("mem_wren", DW'(mem_wren), DW'(ewren));
      chk("mem_addr", DW'(mem_addr), m_v ? DW'(s_addr[m_own*AW +: AW]) : '0);
      if (ewren != '0) chk("mem_wdata", mem_wdata, ewd);
    end
    // Next owner from the arbitration rules.
    if (r) begin
      m_v = 0; m_own = 0; m_hold = 0;
    end else begin
      others = 0;
      for (int j = 0; j < NC; j++) if (j != m_own && rq[j]) others = 1;
      tmo = m_v && (m_hold == MH) && others;
      if (m_v && rq[m_own] && lk[m_own] && !tmo) begin
        nv = 1; no = m_own;
      end else begin
        nv = 0; no = 0;
        for (int j = 0; j < NC; j++) begin
          if (!nv && rq[j] && !(tmo && j == m_own)) begin nv = 1; no = j; end
        end
      end
      if (nv != m_v || no != m_own) nh = 0;
      else if (m_v) nh = (m_hold < MH) ? m_hold + 1 : MH;
      else nh = 0;
      m_v = nv; m_own = no; m_hold = nh;
    end
    if (r) known = 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: pops the scoreboard whenever a response is presented or owed.
  always @(negedge clk) begin
    if (known) begin
      if (|rvalid || sel_err) begin
        n_vec++;
        if (sbq.size() == 0 || sbq[0].due != cyc) begin
          n_bad++;
          $display("FAIL unexpected_resp cyc=%0d: got rvalid=%b sel_err=%b want none", cyc, rvalid, sel_err);
        end else begin
          resp_t e;
          e = sbq.pop_front();
          if (rvalid !== e.rv || sel_err !== e.err || rdata !== e.data) begin
            n_bad++;
            $display("FAIL resp cyc=%0d: got rv=%b err=%b data=%h want rv=%b err=%b data=%h",
                     cyc, rvalid, sel_err, rdata, e.rv, e.err, e.data);
          end
        end
      end else begin
        n_vec++;
        if (sbq.size() != 0 && sbq[0].due == cyc) begin
          n_bad++;
          $display("FAIL missing_resp cyc=%0d: got none want rv=%b err=%b", cyc, sbq[0].rv, sbq[0].err);
          void'(sbq.pop_front());
        end else if (rdata !== '0) begin
          n_bad++;
          $display("FAIL rdata_idle cyc=%0d: got %h want 0", cyc, rdata);
        end
      end
    end
  end

  initial begin
    logic [NC-1:0] rq, lk;
    logic r;
    for (int b = 0; b < NP; b++)
      for (int a = 0; a < 32; a++) begin
        bmem[b][a] = {$urandom, $urandom};
        ref_mem[b][a] = bmem[b][a];
      end
    m_v = 0; m_own = 0; m_hold = 0;
    s_we = '0; s_sel = '0; s_addr = '0; s_wdata = '0;
    @(posedge clk); #1;
    step(1, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000);

    // VGA read of bank 1 word 7.
    cli(3, 0, 1, 7, '0);
    step(0, 4'b1000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000);

    // Simultaneous requests; validador writes 0xAA to bank 0 addr 3.
    cli(0, 1, 0, 3, 64'hAA);
    step(0, 4'b1001, 4'b0000);
    step(0, 4'b1001, 4'b0000);
    step(0, 4'b0000, 4'b0000);

    // Locked VGA starved-out after the hold limit by colisor.
    cli(3, 0, 0, 9, '0);
    cli(1, 0, 2, 4, '0);
    for (int k = 0; k < 3; k++) step(0, 4'b1000, 4'b1000);
    for (int k = 0; k < 25; k++) step(0, 4'b1010, 4'b1000);
    step(0, 4'b0000, 4'b0000);

    // Pontuacao locked for a long read burst.
    for (int k = 0; k < 34; k++) begin
      cli(2, 0, k % 3, k, '0);
      step(0, 4'b0100, 4'b0100);
    end
    step(0, 4'b0000, 4'b0000);

    // Access to a non-existent bank.
    cli(0, 1, 3, 5, 64'h55);
    step(0, 4'b0001, 4'b0000);
    step(0, 4'b0001, 4'b0000);
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000);

    // Reset lands on the edge closing a read access.
    cli(3, 0, 1, 2, '0);
    step(0, 4'b1000, 4'b0000);
    step(1, 4'b1000, 4'b0000);
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000);

    // Randomized traffic with sticky locks.
    lk = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NC; i++)
        cli(i, ($urandom_range(3) == 0), $urandom_range(3), $urandom_range(31), {$urandom, $urandom});
      if ($urandom_range(31) == 0) lk = 4'($urandom);
      rq = (4'($urandom) & 4'($urandom)) | lk;
      r  = ($urandom_range(299) == 0);
      step(r, rq, lk);
    end
    s_we = '0;
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000);
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
